// File: rtl/instr_block_memory_pkg.sv
// ---------------------------------------------------------------------------
// instr_block_memory_pkg
//   Definitions shared by the instruction cache and the instruction block
//   memory that sits below it:
//     - imem_state_e   : responder FSM encoding (IDLE / BUSY / DONE)
//     - DEF_*          : default geometry and read latency
//     - imem_cnt_width : width of a down-counter that must hold LATENCY-1
// ---------------------------------------------------------------------------
package instr_block_memory_pkg;

  localparam int DEF_MEM_BYTES   = 1024;
  localparam int DEF_BLOCK_BYTES = 16;
  localparam int DEF_LATENCY     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } imem_state_e;

  // Counter width able to hold LATENCY-1; never narrower than one bit.
  function automatic int imem_cnt_width(input int latency);
    int width_v;
    width_v = 1;
    if (latency > 2) begin
      width_v = $clog2(latency);
    end else begin
      width_v = 1;
    end
    return width_v;
  endfunction

endpackage : instr_block_memory_pkg

// File: rtl/imem_byte_array.sv
// ---------------------------------------------------------------------------
// imem_byte_array
//   MEM_BYTES x 8 instruction storage. Synchronous single-byte write port and
//   a combinational read port that presents one whole aligned block.
//   Storage has no reset: program images survive a block reset.
// Ports
//   clk         in   1              rising-edge clock
//   wr_en       in   1              write wr_data at wr_addr on this edge
//   wr_addr     in   BYTE_AW        byte address of the write
//   wr_data     in   8              byte to write
//   rd_blk_addr in   BLK_AW         block address to present
//   rd_block    out  8*BLOCK_BYTES  block contents, byte k at [8k+7:8k]
// ---------------------------------------------------------------------------
module imem_byte_array
  import instr_block_memory_pkg::*;
#(
  parameter int MEM_BYTES   = DEF_MEM_BYTES,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int BLK_AW      = $clog2(MEM_BYTES / BLOCK_BYTES),
  parameter int BYTE_AW     = $clog2(MEM_BYTES)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [BYTE_AW-1:0]       wr_addr,
  input  logic [7:0]               wr_data,
  input  logic [BLK_AW-1:0]        rd_blk_addr,
  output logic [8*BLOCK_BYTES-1:0] rd_block
);

  localparam int OFF_W = BYTE_AW - BLK_AW;

  logic [7:0] mem_r [MEM_BYTES];

  // Byte write port; the old byte stays visible on rd_block until the edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  // Little-endian block assembly: lane k carries byte {rd_blk_addr, k}.
  for (genvar k = 0; k < BLOCK_BYTES; k++) begin : g_lane
    assign rd_block[8*k +: 8] = mem_r[{rd_blk_addr, OFF_W'(k)}];
  end

endmodule : imem_byte_array

// File: rtl/instr_block_memory.sv
// ---------------------------------------------------------------------------
// instr_block_memory
//   Responder on the instruction-fetch path below the instruction cache.
//   A READ request is stalled with BUSYWAIT for the request cycle plus
//   LATENCY BUSY cycles, after which the aligned block is registered into
//   READDATA and presented for one DONE cycle with BUSYWAIT low.
//   A byte-wide LOAD port writes the store in any state.
// Ports
//   CLK        in   1              rising-edge clock
//   RESET      in   1              synchronous, active-high reset
//   READ       in   1              block read request (held until BUSYWAIT low)
//   ADDRESS    in   BLK_AW         block address
//   READDATA   out  8*BLOCK_BYTES  returned block, byte k at [8k+7:8k]
//   BUSYWAIT   out  1              initiator must stall while high
//   LOAD_EN    in   1              write LOAD_DATA at LOAD_ADDR this edge
//   LOAD_ADDR  in   LOAD_AW        byte address for LOAD
//   LOAD_DATA  in   8              byte to store
// ---------------------------------------------------------------------------
module instr_block_memory
  import instr_block_memory_pkg::*;
#(
  parameter int MEM_BYTES   = DEF_MEM_BYTES,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int BLK_AW      = $clog2(MEM_BYTES / BLOCK_BYTES),
  parameter int LOAD_AW     = $clog2(MEM_BYTES)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic [BLK_AW-1:0]        ADDRESS,
  output logic [8*BLOCK_BYTES-1:0] READDATA,
  output logic                     BUSYWAIT,
  input  logic                     LOAD_EN,
  input  logic [LOAD_AW-1:0]       LOAD_ADDR,
  input  logic [7:0]               LOAD_DATA
);

  localparam int                CNT_W    = imem_cnt_width(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  imem_state_e                state_r;
  imem_state_e                state_next_s;
  logic [CNT_W-1:0]           cnt_r;
  logic [BLK_AW-1:0]          addr_r;
  logic [8*BLOCK_BYTES-1:0]   readdata_r;
  logic [8*BLOCK_BYTES-1:0]   rd_block_s;
  logic                       busywait_s;
  logic                       start_s;
  logic                       finish_s;

  // Storage; the block read is combinational so a same-edge LOAD is not seen.
  imem_byte_array #(
    .MEM_BYTES   (MEM_BYTES),
    .BLOCK_BYTES (BLOCK_BYTES),
    .BLK_AW      (BLK_AW),
    .BYTE_AW     (LOAD_AW)
  ) u_array (
    .clk         (CLK),
    .wr_en       (LOAD_EN),
    .wr_addr     (LOAD_ADDR),
    .wr_data     (LOAD_DATA),
    .rd_blk_addr (addr_r),
    .rd_block    (rd_block_s)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; READ is only looked at in IDLE, so a dropped READ
  // never aborts a read and a held READ restarts only after DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (READ) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; BUSYWAIT follows READ in IDLE so the request cycle stalls.
  always_comb begin
    busywait_s = 1'b0;
    start_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busywait_s = READ;
        start_s    = READ;
      end
      ST_BUSY: begin
        busywait_s = 1'b1;
        finish_s   = (cnt_r == CNT_ZERO);
      end
      ST_DONE: begin
        busywait_s = 1'b0;
      end
      default: begin
        busywait_s = 1'b0;
      end
    endcase
  end

  // Latency down-counter: loaded on request, counts to zero in BUSY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= CNT_ZERO;
    end else if (start_s) begin
      cnt_r <= CNT_LOAD;
    end else if ((state_r == ST_BUSY) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Request address latch; ADDRESS is ignored outside the request cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_r <= {BLK_AW{1'b0}};
    end else if (start_s) begin
      addr_r <= ADDRESS;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Returned block register: changes only on entry to DONE or on reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      readdata_r <= {(8*BLOCK_BYTES){1'b0}};
    end else if (finish_s) begin
      readdata_r <= rd_block_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  assign READDATA = readdata_r;
  assign BUSYWAIT = busywait_s;

endmodule : instr_block_memory
